sw_ctrl: RTL and testbench

Run/stop/clear/lap controller for the 4-digit BCD stopwatch counter chain. Synchronises and edge-detects two push-buttons, runs a state machine, and drives the chain with a single-cycle count-enable pulse (TICK, into the least-significant digit's button/enable input) and a single-cycle synchronous clear. Also provides run and display-freeze status for the 7-segment display path.

---
 rtl/sw_ctrl_if.sv | 24 ++
 rtl/sw_ctrl.sv | 124 ++++++++++++
 tb/tb_sw_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sw_ctrl_if.sv
// -----------------------------------------------------------------------------
// sw_ctrl_if : button inputs and chain/display control outputs of the stopwatch
// run/stop/clear/lap controller. The master side drives the buttons and observes
// the outputs. The slave side is the controller itself.
// -----------------------------------------------------------------------------
interface sw_ctrl_if;
    logic       BTN_SS;   // start/stop push-button, asynchronous level
    logic       BTN_CL;   // clear/lap push-button, asynchronous level
    logic       TICK;     // one-cycle count enable into digit 0
    logic       CLR;      // one-cycle synchronous clear for all digits
    logic       RUN;      // counting (RUN or LAP)
    logic       FRZ;      // display freeze (LAP only)
    logic [1:0] STATE;    // IDLE=0, RUN=1, STOP=2, LAP=3

    modport master (
        output BTN_SS, BTN_CL,
        input  TICK, CLR, RUN, FRZ, STATE
    );

    modport slave (
        input  BTN_SS, BTN_CL,
        output TICK, CLR, RUN, FRZ, STATE
    );
endinterface

// File: rtl/sw_ctrl.sv
// -----------------------------------------------------------------------------
// sw_ctrl : run/stop/clear/lap controller for the 4-digit BCD stopwatch chain.
// Each button is synchronised by two flops and followed by a history flop, and
// a rising edge is taken as s1 & ~p. A 4-state FSM issues a registered one-cycle
// CLR. A prescaler produces a one-cycle TICK every DIV cycles while counting.
// Optional feature: define SWCTRL_LAP_EN to enable the LAP state and the FRZ output.
// -----------------------------------------------------------------------------
module sw_ctrl #(
    parameter int DIV = 100000
) (
    input  logic      CLK,
    input  logic      RST,
    sw_ctrl_if.slave  bus
);
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2,
        ST_LAP  = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_clr;
    logic [PW-1:0] r_pcnt;

    logic r_ss_s0, r_ss_s1, r_ss_p;
    logic r_cl_s0, r_cl_s1, r_cl_p;

    logic w_ss_edge;
    logic w_cl_edge;
    logic w_counting;
    logic w_pcnt_last;
    logic w_clear_go;

    // Synchronise both buttons and keep one cycle of history for edge detection.
    // NOTE: sequential state uses non-blocking assignments, so every flop in the
    // chain samples its predecessor's old value and the chain shifts one stage per edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ss_s0 <= 1'b0;
            r_ss_s1 <= 1'b0;
            r_ss_p  <= 1'b0;
            r_cl_s0 <= 1'b0;
            r_cl_s1 <= 1'b0;
            r_cl_p  <= 1'b0;
        end else begin
            r_ss_s0 <= bus.BTN_SS;
            r_ss_s1 <= r_ss_s0;
            r_ss_p  <= r_ss_s1;
            r_cl_s0 <= bus.BTN_CL;
            r_cl_s1 <= r_cl_s0;
            r_cl_p  <= r_cl_s1;
        end
    end

    assign w_ss_edge   = r_ss_s1 & ~r_ss_p;
    assign w_cl_edge   = r_cl_s1 & ~r_cl_p;
    assign w_counting  = (r_state == ST_RUN) || (r_state == ST_LAP);
    assign w_pcnt_last = (r_pcnt == PCNT_LAST);
    // A CL edge clears only from IDLE or STOP, and only if SS did not win this cycle.
    assign w_clear_go  = w_cl_edge & ~w_ss_edge &
                         ((r_state == ST_IDLE) || (r_state == ST_STOP));

    // Controller FSM with the registered one-cycle CLR pulse. SS has priority over CL.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_clr   <= 1'b0;
        end else begin
            r_clr <= w_clear_go;
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_edge) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_ss_edge) r_state <= ST_STOP;
`ifdef SWCTRL_LAP_EN
                    else if (w_cl_edge) r_state <= ST_LAP;
`endif
                end
                ST_STOP: begin
                    if (w_ss_edge)      r_state <= ST_RUN;
                    else if (w_cl_edge) r_state <= ST_IDLE;
                end
                ST_LAP: begin
`ifdef SWCTRL_LAP_EN
                    if (w_ss_edge)      r_state <= ST_STOP;
                    else if (w_cl_edge) r_state <= ST_RUN;
`else
                    // LAP is not a legal state in this build: recover to IDLE.
                    r_state <= ST_IDLE;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Prescaler: wraps 0..DIV-1 while counting, holds otherwise, zeroed with CLR.
    // The increment is based on the pre-edge state, so stopping on a TICK still wraps to 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pcnt <= '0;
        end else if (w_clear_go) begin
            r_pcnt <= '0;
        end else if (w_counting) begin
            r_pcnt <= w_pcnt_last ? '0 : r_pcnt + 1'b1;
        end
    end

    assign bus.TICK  = w_counting & w_pcnt_last;
    assign bus.CLR   = r_clr;
    assign bus.RUN   = w_counting;
`ifdef SWCTRL_LAP_EN
    assign bus.FRZ   = (r_state == ST_LAP);
`else
    assign bus.FRZ   = 1'b0;
`endif
    assign bus.STATE = r_state;

endmodule

// File: tb/tb_sw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sw_ctrl : directed and random stimulus for sw_ctrl with DIV=4. A behavioural
// model tracks mode, prescaler and the per-button sample history and predicts
// every output each cycle. Works with or without SWCTRL_LAP_EN.
// -----------------------------------------------------------------------------
module tb_sw_ctrl;
    localparam int DIV = 4;

    logic CLK = 1'b0;
    logic RST;

    sw_ctrl_if bus ();

    sw_ctrl #(.DIV(DIV)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: mode 0=IDLE 1=RUN 2=STOP 3=LAP.
    int   m_mode;
    int   m_pcnt;
    bit   m_clr;
    bit   ss_h [3];   // [0] newest sampled level, [2] oldest
    bit   cl_h [3];

    int n_tests = 0;
    int n_fail  = 0;
    int n_tick  = 0;
    int n_clr   = 0;

`ifdef SWCTRL_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pcnt = 0;
        m_clr  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ss_h[i] = 1'b0;
            cl_h[i] = 1'b0;
        end
    endtask

    // One clock edge of the model; ss/cl are the levels present at that edge.
    task automatic model_edge(input bit ss, input bit cl);
        bit ss_e, cl_e, counting;
        int nmode, npcnt;
        bit nclr;
        ss_e     = ss_h[1] && !ss_h[2];
        cl_e     = cl_h[1] && !cl_h[2];
        counting = (m_mode == 1) || (m_mode == 3);
        nmode    = m_mode;
        npcnt    = counting ? (m_pcnt + 1) % DIV : m_pcnt;
        nclr     = 1'b0;
        if (ss_e) begin
            case (m_mode)
                0: nmode = 1;
                1: nmode = 2;
                2: nmode = 1;
                default: nmode = LAP_EN ? 2 : 0;
            endcase
        end else if (cl_e) begin
            case (m_mode)
                0, 2: begin nmode = 0; nclr = 1'b1; npcnt = 0; end
                1: nmode = LAP_EN ? 3 : 1;
                default: nmode = LAP_EN ? 1 : 0;
            endcase
        end else if (m_mode == 3 && !LAP_EN) begin
            nmode = 0;
        end
        m_mode  = nmode;
        m_pcnt  = npcnt;
        m_clr   = nclr;
        ss_h[2] = ss_h[1]; ss_h[1] = ss_h[0]; ss_h[0] = ss;
        cl_h[2] = cl_h[1]; cl_h[1] = cl_h[0]; cl_h[0] = cl;
    endtask

    task automatic cmp_all(input string tag);
        bit counting;
        counting = (m_mode == 1) || (m_mode == 3);
        check({tag, ".TICK"},  bus.TICK,  counting && (m_pcnt == DIV - 1));
        check({tag, ".CLR"},   bus.CLR,   m_clr);
        check({tag, ".RUN"},   bus.RUN,   counting);
        check({tag, ".FRZ"},   bus.FRZ,   m_mode == 3);
        check({tag, ".STATE"}, bus.STATE, m_mode);
        check({tag, ".pcnt"},  dut.r_pcnt, m_pcnt);
    endtask

    // Drive levels, clock once, compare on the falling edge.
    task automatic step(input bit ss, input bit cl, input string tag);
        bus.BTN_SS = ss;
        bus.BTN_CL = cl;
        @(posedge CLK);
        model_edge(ss, cl);
        @(negedge CLK);
        cmp_all(tag);
        if (bus.TICK === 1'b1) n_tick++;
        if (bus.CLR === 1'b1)  n_clr++;
    endtask

    task automatic press_ss(input string tag);
        step(1'b1, 1'b0, tag);
        step(1'b0, 1'b0, tag);
        step(1'b0, 1'b0, tag);
    endtask

    task automatic press_cl(input string tag);
        step(1'b0, 1'b1, tag);
        step(1'b0, 1'b0, tag);
        step(1'b0, 1'b0, tag);
    endtask

    initial begin
        bit ss, cl;

        // Reset state
        RST        = 1'b1;
        bus.BTN_SS = 1'b0;
        bus.BTN_CL = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        cmp_all("reset");
        RST = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "idle");

        // Start and tick rate: 10 TICKs over the first 40 RUN cycles
        step(1'b1, 1'b0, "start");
        step(1'b0, 1'b0, "start");
        n_tick = 0;
        step(1'b0, 1'b0, "start");
        check("start_run", bus.RUN, 1'b1);
        for (int i = 0; i < 39; i++) step(1'b0, 1'b0, "rate");
        check("tick_count_40", n_tick, 10);

        // Stop with phase held, no TICK while stopped, resume keeps phase
        press_ss("stop");
        check("stop_state", bus.STATE, 2);
        n_tick = 0;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "stopped");
        check("stopped_ticks", n_tick, 0);
        press_ss("resume");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "resumed");

        // Stop landing on a TICK cycle: prescaler still wraps
        for (int i = 0; i < 2 * DIV && m_pcnt != DIV - 3; i++) step(1'b0, 1'b0, "align");
        check("align_reached", m_pcnt == DIV - 3, 1'b1);
        press_ss("stop_on_tick");
        check("stop_on_tick_pcnt", dut.r_pcnt, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "stopped2");

        // Clear from STOP with CL held 50 cycles: exactly one CLR
        n_clr = 0;
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, "clr_hold");
        step(1'b0, 1'b0, "clr_rel");
        check("clr_count", n_clr, 1);
        check("clr_idle", bus.STATE, 0);

        // Lap: ticks continue; second CL returns to RUN
        press_ss("lap_start");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "lap_run");
        press_cl("lap_enter");
        n_tick = 0;
        for (int i = 0; i < 2 * DIV; i++) step(1'b0, 1'b0, "lap_hold");
        check("lap_ticks", n_tick, 2);
        press_cl("lap_exit");
        check("lap_exit_state", bus.STATE, 1);

        // Simultaneous SS and CL edges in STOP: SS wins, no CLR
        press_ss("sim_stop");
        step(1'b1, 1'b1, "sim");
        step(1'b0, 1'b0, "sim");
        step(1'b0, 1'b0, "sim");
        check("sim_state", bus.STATE, 1);

        // Random button activity against the model
        ss = 1'b0;
        cl = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(5) == 0) ss = ~ss;
            if ($urandom_range(6) == 0) cl = ~cl;
            step(ss, cl, "rand");
        end

        // Make sure it is running, then assert reset mid-cycle
        if (m_mode != 1 && m_mode != 3) begin
            step(1'b0, 1'b0, "pre_rst");
            step(1'b0, 1'b0, "pre_rst");
            step(1'b0, 1'b0, "pre_rst");
            if (m_mode == 0 || m_mode == 2) press_ss("pre_rst");
        end
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "pre_rst");
        #2 RST = 1'b1;
        #1 model_reset();
        cmp_all("async_rst");
        @(negedge CLK);
        cmp_all("rst_held");
        RST = 1'b0;
        n_tick = 0;
        n_clr  = 0;
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, "post_rst");
        check("post_rst_ticks", n_tick, 0);
        check("post_rst_clrs", n_clr, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit");
    end
endmodule
